// File: rtl/audio_pkg.sv
// Shared types and default widths for the tone generator datapath.
package audio_pkg;

    localparam int ACC_WIDTH_DEF  = 24;
    localparam int COUNT_SIZE_DEF = 8;
    localparam int DUR_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        FINISH = 2'd2
    } tone_state_t;

endpackage

// File: rtl/tone_phase_gen_phase_accum.sv
// Phase accumulator: phase and frequency-word registers with free-wrapping
// phase add. Optional linear frequency sweep guarded by TONE_SWEEP_EN.
module phase_accum
    import audio_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 clear,
    input  logic                 step,
    input  logic [ACC_WIDTH-1:0] freq_word,
`ifdef TONE_SWEEP_EN
    input  logic [ACC_WIDTH-1:0] sweep_step,
`endif
    output logic [ACC_WIDTH-1:0] phase
);

    logic [ACC_WIDTH-1:0] phase_q, phase_d;
    logic [ACC_WIDTH-1:0] freq_r_q, freq_r_d;

`ifdef TONE_SWEEP_EN
    logic [ACC_WIDTH-1:0] sweep_q, sweep_d;

    // Add a signed delta to an unsigned frequency word, clamping to [0, max].
    function automatic logic [ACC_WIDTH-1:0] sweep_sat(
        input logic [ACC_WIDTH-1:0] f,
        input logic [ACC_WIDTH-1:0] s
    );
        logic [ACC_WIDTH+1:0] sum;
        sum = {2'b00, f} + {{2{s[ACC_WIDTH-1]}}, s};
        if (sum[ACC_WIDTH+1])
            sweep_sat = '0;
        else if (sum[ACC_WIDTH])
            sweep_sat = '1;
        else
            sweep_sat = sum[ACC_WIDTH-1:0];
    endfunction
`endif

    // Next phase / frequency: load wins over clear, clear over step.
    always_comb begin
        phase_d  = phase_q;
        freq_r_d = freq_r_q;
`ifdef TONE_SWEEP_EN
        sweep_d  = sweep_q;
`endif
        if (load) begin
            phase_d  = '0;
            freq_r_d = freq_word;
`ifdef TONE_SWEEP_EN
            sweep_d  = sweep_step;
`endif
        end else if (clear) begin
            phase_d = '0;
        end else if (step) begin
            // Phase always advances by the frequency in force before this tick.
            phase_d = phase_q + freq_r_q;
`ifdef TONE_SWEEP_EN
            freq_r_d = sweep_sat(freq_r_q, sweep_q);
`endif
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q  <= '0;
            freq_r_q <= '0;
`ifdef TONE_SWEEP_EN
            sweep_q  <= '0;
`endif
        end else begin
            phase_q  <= phase_d;
            freq_r_q <= freq_r_d;
`ifdef TONE_SWEEP_EN
            sweep_q  <= sweep_d;
`endif
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/tone_phase_gen.sv
// NCO tone generator feeding an 8-bit sine table: FSM, duration counter and
// the sample-valid delay line matching the phase register plus table register.
// Optional macro TONE_SWEEP_EN adds the sweep_step port and frequency sweep.
module tone_phase_gen
    import audio_pkg::*;
#(
    parameter int COUNT_SIZE = COUNT_SIZE_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int DUR_WIDTH  = DUR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ACC_WIDTH-1:0]  freq_word,
    input  logic [DUR_WIDTH-1:0]  duration,
`ifdef TONE_SWEEP_EN
    input  logic [ACC_WIDTH-1:0]  sweep_step,
`endif
    output logic [COUNT_SIZE-1:0] ADDR,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  done
);

    tone_state_t          state_q, state_d;
    logic [DUR_WIDTH-1:0] dur_cnt_q, dur_cnt_d;
    logic                 vld_p1_q, vld_p1_d;
    logic                 vld_p2_q, vld_p2_d;
    logic                 accept, load, clear, step, kill;
    logic [ACC_WIDTH-1:0] phase;

    phase_accum #(.ACC_WIDTH(ACC_WIDTH)) u_phase_accum (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .clear      (clear),
        .step       (step),
        .freq_word  (freq_word),
`ifdef TONE_SWEEP_EN
        .sweep_step (sweep_step),
`endif
        .phase      (phase)
    );

    // FSM next state, accumulator controls and valid pipeline; stop beats start beats tick.
    always_comb begin
        state_d   = state_q;
        dur_cnt_d = dur_cnt_q;
        accept    = 1'b0;
        load      = 1'b0;
        clear     = 1'b0;
        step      = 1'b0;
        kill      = 1'b0;
        case (state_q)
            IDLE: begin
                accept = start && !stop;
            end
            PLAY: begin
                if (stop) begin
                    clear     = 1'b1;
                    kill      = 1'b1;
                    dur_cnt_d = '0;
                    state_d   = IDLE;
                end else if (start) begin
                    accept = 1'b1;
                    kill   = 1'b1;
                end else if (sample_tick) begin
                    step      = 1'b1;
                    dur_cnt_d = dur_cnt_q - DUR_WIDTH'(1);
                    if (dur_cnt_q == DUR_WIDTH'(1))
                        state_d = FINISH;
                end
            end
            FINISH: begin
                // Silence the table: phase returns to zero unless a new tone starts.
                accept = start && !stop;
                if (!accept) begin
                    clear   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                clear   = 1'b1;
                state_d = IDLE;
            end
        endcase
        if (accept) begin
            load      = 1'b1;
            dur_cnt_d = duration;
            state_d   = (duration == '0) ? FINISH : PLAY;
        end
        vld_p1_d = step && !kill;
        vld_p2_d = vld_p1_q && !kill;
    end

    // State, duration counter and valid delay registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            dur_cnt_q <= '0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dur_cnt_q <= dur_cnt_d;
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
        end
    end

    assign ADDR         = phase[ACC_WIDTH-1 -: COUNT_SIZE];
    assign sample_valid = vld_p2_q;
    assign busy         = (state_q == PLAY);
    assign done         = (state_q == FINISH);

endmodule

// File: tb/tb_tone_phase_gen.sv
// Directed self-checking bench for tone_phase_gen.
module tb_tone_phase_gen;

    logic        clk = 1'b0;
    logic        reset, sample_tick, start, stop;
    logic [23:0] freq_word;
    logic [15:0] duration;
`ifdef TONE_SWEEP_EN
    logic [23:0] sweep_step;
`endif
    logic [7:0]  ADDR;
    logic        sample_valid, busy, done;

    int n_checks = 0;
    int n_errors = 0;
    int vld_total = 0;
    int done_total = 0;
    int vld_mark, done_mark;

    tone_phase_gen dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .start        (start),
        .stop         (stop),
        .freq_word    (freq_word),
        .duration     (duration),
`ifdef TONE_SWEEP_EN
        .sweep_step   (sweep_step),
`endif
        .ADDR         (ADDR),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sample_valid) vld_total = vld_total + 1;
        if (done)         done_total = done_total + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
    endtask

    task automatic begin_tone(input logic [23:0] f, input logic [15:0] d);
        freq_word = f;
        duration  = d;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
    endtask

    task automatic mark();
        vld_mark  = vld_total;
        done_mark = done_total;
    endtask

    initial begin
        reset = 1'b1; sample_tick = 1'b0; start = 1'b0; stop = 1'b0;
        freq_word = '0; duration = '0;
`ifdef TONE_SWEEP_EN
        sweep_step = '0;
`endif
        repeat (3) cycle();
        check_eq("rst_addr",  {24'd0, ADDR}, 32'h0);
        check_eq("rst_busy",  {31'd0, busy}, 32'h0);
        check_eq("rst_done",  {31'd0, done}, 32'h0);
        check_eq("rst_valid", {31'd0, sample_valid}, 32'h0);
        reset = 1'b0;
        cycle();

        // Test 1: basic tone, four samples
        mark();
        begin_tone(24'h010000, 16'd4);
        check_eq("t1_busy", {31'd0, busy}, 32'h1);
        check_eq("t1_addr0", {24'd0, ADDR}, 32'h00);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_eq($sformatf("t1_addr%0d", k), {24'd0, ADDR}, k);
            if (k < 4) repeat (9) cycle();
        end
        check_eq("t1_done", {31'd0, done}, 32'h1);
        check_eq("t1_busy_end", {31'd0, busy}, 32'h0);
        cycle();
        check_eq("t1_addr_silent", {24'd0, ADDR}, 32'h00);
        check_eq("t1_done_pulse", {31'd0, done}, 32'h0);
        repeat (3) cycle();
        check_eq("t1_valids", vld_total - vld_mark, 4);
        check_eq("t1_dones", done_total - done_mark, 1);

        // Test 2: wrapping phase
        mark();
        begin_tone(24'hC00000, 16'd3);
        tick();
        check_eq("t2_addr1", {24'd0, ADDR}, 32'hC0);
        repeat (9) cycle();
        tick();
        check_eq("t2_addr2", {24'd0, ADDR}, 32'h80);
        repeat (9) cycle();
        tick();
        check_eq("t2_addr3", {24'd0, ADDR}, 32'h40);
        check_eq("t2_done", {31'd0, done}, 32'h1);
        cycle();
        check_eq("t2_addr_silent", {24'd0, ADDR}, 32'h00);
        repeat (3) cycle();
        check_eq("t2_valids", vld_total - vld_mark, 3);
        check_eq("t2_dones", done_total - done_mark, 1);

        // Test 3: zero duration
        mark();
        begin_tone(24'h010000, 16'd0);
        check_eq("t3_done", {31'd0, done}, 32'h1);
        check_eq("t3_busy", {31'd0, busy}, 32'h0);
        check_eq("t3_addr", {24'd0, ADDR}, 32'h00);
        cycle();
        tick();
        check_eq("t3_idle_tick_addr", {24'd0, ADDR}, 32'h00);
        repeat (4) cycle();
        check_eq("t3_valids", vld_total - vld_mark, 0);
        check_eq("t3_dones", done_total - done_mark, 1);

        // Test 4: stop aborts; start+stop together ignored
        mark();
        begin_tone(24'h010000, 16'd10);
        tick();
        repeat (9) cycle();
        tick();
        check_eq("t4_addr2", {24'd0, ADDR}, 32'h02);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check_eq("t4_busy", {31'd0, busy}, 32'h0);
        check_eq("t4_addr", {24'd0, ADDR}, 32'h00);
        tick();
        repeat (4) cycle();
        check_eq("t4_valids", vld_total - vld_mark, 1);
        check_eq("t4_dones", done_total - done_mark, 0);
        freq_word = 24'h010000; duration = 16'd5;
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        check_eq("t4_ss_idle_busy", {31'd0, busy}, 32'h0);
        begin_tone(24'h010000, 16'd5);
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        check_eq("t4_ss_play_busy", {31'd0, busy}, 32'h0);
        check_eq("t4_ss_play_addr", {24'd0, ADDR}, 32'h00);

        // Test 5: retrigger, then reset mid-tone
        cycle();
        mark();
        begin_tone(24'h010000, 16'd5);
        tick();
        repeat (9) cycle();
        tick();
        begin_tone(24'h020000, 16'd2);
        check_eq("t5_retrig_busy", {31'd0, busy}, 32'h1);
        check_eq("t5_retrig_addr", {24'd0, ADDR}, 32'h00);
        repeat (9) cycle();
        tick();
        check_eq("t5_addr1", {24'd0, ADDR}, 32'h02);
        repeat (9) cycle();
        tick();
        check_eq("t5_addr2", {24'd0, ADDR}, 32'h04);
        check_eq("t5_done", {31'd0, done}, 32'h1);
        repeat (4) cycle();
        check_eq("t5_valids", vld_total - vld_mark, 3);
        check_eq("t5_dones", done_total - done_mark, 1);
        begin_tone(24'h010000, 16'd5);
        tick();
        check_eq("t5_pre_reset_addr", {24'd0, ADDR}, 32'h01);
        reset = 1'b1;
        cycle();
        check_eq("t5_rst_addr", {24'd0, ADDR}, 32'h00);
        check_eq("t5_rst_busy", {31'd0, busy}, 32'h0);
        check_eq("t5_rst_valid", {31'd0, sample_valid}, 32'h0);
        check_eq("t5_rst_done", {31'd0, done}, 32'h0);
        reset = 1'b0;
        cycle();

`ifdef TONE_SWEEP_EN
        // Test 6: frequency sweep up, then clamp at zero
        sweep_step = 24'h010000;
        begin_tone(24'h010000, 16'd3);
        tick();
        check_eq("t6_up1", {24'd0, ADDR}, 32'h01);
        repeat (9) cycle();
        tick();
        check_eq("t6_up2", {24'd0, ADDR}, 32'h03);
        repeat (9) cycle();
        tick();
        check_eq("t6_up3", {24'd0, ADDR}, 32'h06);
        repeat (3) cycle();
        sweep_step = 24'hFE0000;
        begin_tone(24'h010000, 16'd3);
        tick();
        check_eq("t6_dn1", {24'd0, ADDR}, 32'h01);
        repeat (9) cycle();
        tick();
        check_eq("t6_dn2", {24'd0, ADDR}, 32'h01);
        repeat (9) cycle();
        tick();
        check_eq("t6_dn3", {24'd0, ADDR}, 32'h01);
        repeat (3) cycle();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
